// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with an 8-deep show-ahead receive FIFO.
// The RXD input passes through a two-flop synchronizer. A falling edge starts a
// frame. Bits are sampled at mid-bit using a reloading baud down-counter. One
// or two stop bits are checked, and good bytes are pushed into the FIFO.
// Build option: define UART_RX_MAJORITY_VOTE_EN to use 2-of-3 majority
// sampling. When the macro is undefined, each bit is a single sample.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd_pin_i,
  input  logic        rx_en_i,
  input  logic        two_stop_bits_i,
  input  logic [15:0] baud_rate_i,
  input  logic [2:0]  rx_watermark_i,
  input  logic        rx_fifo_read_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_fifo_empty_o,
  output logic        rx_fifo_mark_o,
  output logic        rx_overrun_o,
  output logic        rx_frame_err_o,
  input  logic        rx_err_clr_i
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Synchronizer and edge-detect history
  logic        rxd_meta_q, rxd_s_q, rxd_prev_q;
  logic        rxd_s;
  // Receive FSM
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        bad_q, bad_d;
  logic        wr_q, wr_d;
  logic        ferr_set;
  // FIFO
  logic [7:0]  mem_q [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        empty_q, empty_d;
  logic        mark_q, mark_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        full, do_rd, do_wr, ovr_set;
  logic        tick, sample;

  assign rxd_s = rxd_s_q;
  assign tick  = (cnt_q == 16'd0);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // At counter 0, rxd_prev_q holds the counter-1 value. rxd_meta_q is what
  // rxd_s will be in the following cycle. Voting now keeps the latency the
  // same as single sampling.
  assign sample = (rxd_prev_q & rxd_s) | (rxd_prev_q & rxd_meta_q) | (rxd_s & rxd_meta_q);
`else
  // Single mid-bit sample of the synchronized line
  assign sample = rxd_s;
`endif

  // Receiver next-state: baud counter, bit assembly, stop-bit check
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    bad_d      = bad_q;
    wr_d       = 1'b0;
    ferr_set   = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = tick ? baud_rate_i : cnt_q - 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (rx_en_i && rxd_prev_q && !rxd_s) begin
          cnt_d   = baud_rate_i >> 1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!sample) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            bad_d      = 1'b0;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!sample) begin
            ferr_set = 1'b1;
            bad_d    = 1'b1;
          end
          if (!two_stop_bits_i || stop_cnt_q) begin
            state_d = IDLE;
            wr_d    = sample & ~bad_q;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the receiver drops any partial frame silently
    if (!rx_en_i) begin
      state_d  = IDLE;
      wr_d     = 1'b0;
      ferr_set = 1'b0;
    end
  end

  // FIFO control, level flags and sticky error flags
  always_comb begin
    full     = (count_q == 4'd8);
    do_rd    = rx_fifo_read_i & (count_q != 4'd0);
    do_wr    = wr_q & (~full | do_rd);
    ovr_set  = wr_q & full & ~do_rd;
    wr_ptr_d = do_wr ? wr_ptr_q + 3'd1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 3'd1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 4'd1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 4'd1;
    end
    empty_d = (count_d == 4'd0);
    mark_d  = (count_q > {1'b0, rx_watermark_i});
    ovr_d   = ovr_set | (ovr_q & ~rx_err_clr_i);
    ferr_d  = ferr_set | (ferr_q & ~rx_err_clr_i);
  end

  // All control state registers, asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 16'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'h00;
      bad_q      <= 1'b0;
      wr_q       <= 1'b0;
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      empty_q    <= 1'b1;
      mark_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd_pin_i;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      wr_q       <= wr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      mark_q     <= mark_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  // FIFO storage. It has no reset because empty_q gates the output.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_data_o       = empty_q ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_fifo_empty_o = empty_q;
  assign rx_fifo_mark_o  = mark_q;
  assign rx_overrun_o    = ovr_q;
  assign rx_frame_err_o  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with baud_rate_i = 15 (16 clocks per bit).
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd_pin_i = 1'b1;
  logic        rx_en_i = 1'b1;
  logic        two_stop_bits_i = 1'b0;
  logic [15:0] baud_rate_i = 16'd15;
  logic [2:0]  rx_watermark_i = 3'd7;
  logic        rx_fifo_read_i = 1'b0;
  logic        rx_err_clr_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_fifo_empty_o, rx_fifo_mark_o, rx_overrun_o, rx_frame_err_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0;
  int start_cyc = 0;
  int empty_fall_cyc = -1;
  int mark_rise_cyc = -1;
  logic empty_prev = 1'b1;
  logic mark_prev  = 1'b0;

  uart_rx dut (
    .clk             (clk),
    .rst             (rst),
    .rxd_pin_i       (rxd_pin_i),
    .rx_en_i         (rx_en_i),
    .two_stop_bits_i (two_stop_bits_i),
    .baud_rate_i     (baud_rate_i),
    .rx_watermark_i  (rx_watermark_i),
    .rx_fifo_read_i  (rx_fifo_read_i),
    .rx_data_o       (rx_data_o),
    .rx_fifo_empty_o (rx_fifo_empty_o),
    .rx_fifo_mark_o  (rx_fifo_mark_o),
    .rx_overrun_o    (rx_overrun_o),
    .rx_frame_err_o  (rx_frame_err_o),
    .rx_err_clr_i    (rx_err_clr_i)
  );

  always #5 clk = ~clk;

  // Count rising clock edges for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge at which empty falls and mark rises
  always @(negedge clk) begin
    if (empty_prev && !rx_fifo_empty_o) empty_fall_cyc <= cyc;
    if (!mark_prev && rx_fifo_mark_o) mark_rise_cyc <= cyc;
    empty_prev <= rx_fifo_empty_o;
    mark_prev  <= rx_fifo_mark_o;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one frame at 16 clocks per bit. last_low forces the final stop bit low.
  task automatic send_frame(input logic [7:0] b, input int nstop, input logic last_low);
    start_cyc = cyc;
    rxd_pin_i = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rxd_pin_i = b[i];
      tick(16);
    end
    for (int s = 0; s < nstop; s++) begin
      rxd_pin_i = (s == nstop - 1 && last_low) ? 1'b0 : 1'b1;
      tick(16);
    end
    rxd_pin_i = 1'b1;
  endtask

  task automatic pop();
    rx_fifo_read_i = 1'b1;
    tick(1);
    rx_fifo_read_i = 1'b0;
  endtask

  initial begin
    tick(3);
    // Check the outputs while reset is held
    check("rst_data",  {24'd0, rx_data_o}, 32'h00);
    check("rst_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    check("rst_mark",  {31'd0, rx_fifo_mark_o}, 32'd0);
    check("rst_ovr",   {31'd0, rx_overrun_o}, 32'd0);
    check("rst_ferr",  {31'd0, rx_frame_err_o}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Receive a basic byte and measure the latency from start bit to empty fall
    send_frame(8'hA5, 1, 1'b0);
    tick(2);
    check("a5_latency", empty_fall_cyc - start_cyc, 32'd156);
    check("a5_data",  {24'd0, rx_data_o}, 32'hA5);
    check("a5_empty", {31'd0, rx_fifo_empty_o}, 32'd0);
    check("a5_ovr",   {31'd0, rx_overrun_o}, 32'd0);
    check("a5_ferr",  {31'd0, rx_frame_err_o}, 32'd0);
    pop();
    check("a5_pop_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    check("a5_pop_data",  {24'd0, rx_data_o}, 32'h00);

    // A read while the FIFO is empty is ignored
    pop();
    check("emptyrd_empty", {31'd0, rx_fifo_empty_o}, 32'd1);

    // A 4-cycle low glitch is a false start
    rxd_pin_i = 1'b0;
    tick(4);
    rxd_pin_i = 1'b1;
    tick(200);
    check("glitch_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    check("glitch_ferr",  {31'd0, rx_frame_err_o}, 32'd0);
    check("glitch_ovr",   {31'd0, rx_overrun_o}, 32'd0);
    send_frame(8'h5A, 1, 1'b0);
    tick(2);
    check("after_glitch", {24'd0, rx_data_o}, 32'h5A);
    pop();

    // Two stop bits with the second stop bit low
    two_stop_bits_i = 1'b1;
    send_frame(8'h3C, 2, 1'b1);
    tick(20);
    check("fe_ferr",  {31'd0, rx_frame_err_o}, 32'd1);
    check("fe_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    rx_err_clr_i = 1'b1;
    tick(1);
    rx_err_clr_i = 1'b0;
    check("fe_clear", {31'd0, rx_frame_err_o}, 32'd0);
    two_stop_bits_i = 1'b0;
    tick(10);

    // Send nine bytes with no reads: eight are stored and the ninth overruns
    for (int i = 1; i <= 9; i++) send_frame(i[7:0], 1, 1'b0);
    tick(4);
    check("ovr_flag", {31'd0, rx_overrun_o}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      check("ovr_read", {24'd0, rx_data_o}, i);
      pop();
    end
    check("ovr_drained", {31'd0, rx_fifo_empty_o}, 32'd1);
    rx_err_clr_i = 1'b1;
    tick(1);
    rx_err_clr_i = 1'b0;
    check("ovr_clear", {31'd0, rx_overrun_o}, 32'd0);

    // Watermark of 2: mark rises one cycle after the third write
    rx_watermark_i = 3'd2;
    tick(2);
    send_frame(8'h11, 1, 1'b0);
    send_frame(8'h22, 1, 1'b0);
    tick(2);
    check("wm_two", {31'd0, rx_fifo_mark_o}, 32'd0);
    send_frame(8'h33, 1, 1'b0);
    tick(2);
    check("wm_latency", mark_rise_cyc - start_cyc, 32'd157);
    check("wm_three", {31'd0, rx_fifo_mark_o}, 32'd1);
    pop();
    check("wm_lag", {31'd0, rx_fifo_mark_o}, 32'd1);
    check("wm_head", {24'd0, rx_data_o}, 32'h22);
    tick(1);
    check("wm_drop", {31'd0, rx_fifo_mark_o}, 32'd0);
    pop();
    pop();
    rx_watermark_i = 3'd7;

    // Reset during bit 4 of 0xFF clears the FIFO and aborts the frame
    send_frame(8'h77, 1, 1'b0);
    tick(2);
    check("pre_rst_data", {24'd0, rx_data_o}, 32'h77);
    rxd_pin_i = 1'b0;
    tick(16);
    rxd_pin_i = 1'b1;
    tick(64 + 8);
    rst = 1'b1;
    tick(2);
    check("mid_rst_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    rst = 1'b0;
    tick(8 + 48 + 16 + 10);
    check("post_rst_empty", {31'd0, rx_fifo_empty_o}, 32'd1);
    send_frame(8'h55, 1, 1'b0);
    tick(2);
    check("post_rst_data", {24'd0, rx_data_o}, 32'h55);
    pop();
    check("post_rst_only", {31'd0, rx_fifo_empty_o}, 32'd1);
    check("post_rst_ferr", {31'd0, rx_frame_err_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
